// File: rtl/exec_alu_if.sv
// Operand/result bundle between register-file read ports, execute stage and write-back.
// Latency: none, wires only.
// Backpressure: none; the master watches busy and issues start only while the stage is idle.
interface exec_alu_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  shamt;
    logic        busy;
    logic        valid;
    logic [31:0] result;
    logic        zf;
    logic        ovf;
    logic        ill;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, shamt,
        input  busy, valid, result, zf, ovf, ill, hi, lo
    );

    modport slave (
        input  start, op, a, b, shamt,
        output busy, valid, result, zf, ovf, ill, hi, lo
    );
endinterface

// File: rtl/exec_alu.sv
// Execute-stage ALU with optional 32-step mul/div engine into HI/LO (macro EXEC_ALU_MULDIV_EN).
// Latency: 1 cycle for logic/arith/shift/MFHI/MFLO; mul/div has valid 33 cycles after accept.
// Backpressure: start is ignored while busy or in the completion cycle; nothing is queued.
module exec_alu (
    input  logic      clk,
    input  logic      rst_n,
    exec_alu_if.slave io
);
    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_NOR  = 4'd5;
    localparam logic [3:0] OP_XOR  = 4'd6;
    localparam logic [3:0] OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL  = 4'd8;
    localparam logic [3:0] OP_SRA  = 4'd9;
    localparam logic [3:0] OP_MULT = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_MFHI = 4'd14;
    localparam logic [3:0] OP_MFLO = 4'd15;

    logic [31:0] result_q, result_d;
    logic        zf_q, zf_d, ovf_q, ovf_d, ill_q, ill_d, valid_q, valid_d;
    logic [31:0] sum, diff, sc_res;
    logic        sc_ovf, sc_ill;

`ifdef EXEC_ALU_MULDIV_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] p_q, p_d;
    logic [31:0] m_q, m_d, hi_q, hi_d, lo_q, lo_d;
    logic        is_div_q, is_div_d, neg_q, neg_d, rneg_q, rneg_d;
    logic        is_md, sa, sb, div_ge, div0;
    logic [31:0] ma, mb, quo_fix, rem_fix;
    logic [32:0] mul_sum, rem_sh, rem_new;
    logic [63:0] step_p, prod_fix;
`endif

    always_comb begin
        sum    = io.a + io.b;
        diff   = io.a - io.b;
        sc_res = '0;
        sc_ovf = 1'b0;
        sc_ill = 1'b0;
        case (io.op)
            OP_AND: sc_res = io.a & io.b;
            OP_OR:  sc_res = io.a | io.b;
            OP_ADD: begin
                sc_res = sum;
                sc_ovf = (io.a[31] == io.b[31]) && (sum[31] != io.a[31]);
            end
            OP_SUB: begin
                sc_res = diff;
                sc_ovf = (io.a[31] != io.b[31]) && (diff[31] != io.a[31]);
            end
            OP_SLT: sc_res = {31'd0, $signed(io.a) < $signed(io.b)};
            OP_NOR: sc_res = ~(io.a | io.b);
            OP_XOR: sc_res = io.a ^ io.b;
            OP_SLL: sc_res = io.b << io.shamt;
            OP_SRL: sc_res = io.b >> io.shamt;
            OP_SRA: sc_res = $unsigned($signed(io.b) >>> io.shamt);
`ifdef EXEC_ALU_MULDIV_EN
            OP_MFHI: sc_res = hi_q;
            OP_MFLO: sc_res = lo_q;
`endif
            default: sc_ill = 1'b1;
        endcase
    end

`ifdef EXEC_ALU_MULDIV_EN
    // Engine works on magnitudes; signs are reapplied when the last step lands.
    always_comb begin
        is_md    = (io.op >= OP_MULT) && (io.op <= 4'd13);
        sa       = ((io.op == OP_MULT) || (io.op == OP_DIV)) && io.a[31];
        sb       = ((io.op == OP_MULT) || (io.op == OP_DIV)) && io.b[31];
        ma       = sa ? (32'd0 - io.a) : io.a;
        mb       = sb ? (32'd0 - io.b) : io.b;
        mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
        rem_sh   = {p_q[63:32], p_q[31]};
        div_ge   = (rem_sh >= {1'b0, m_q});
        rem_new  = div_ge ? (rem_sh - {1'b0, m_q}) : rem_sh;
        step_p   = is_div_q ? {rem_new[31:0], p_q[30:0], div_ge} : {mul_sum, p_q[31:1]};
        prod_fix = neg_q ? (64'd0 - step_p) : step_p;
        quo_fix  = neg_q ? (32'd0 - step_p[31:0]) : step_p[31:0];
        rem_fix  = rneg_q ? (32'd0 - step_p[63:32]) : step_p[63:32];
        div0     = (m_q == 32'd0);
    end
`endif

    always_comb begin
        result_d = result_q;
        ovf_d    = ovf_q;
        ill_d    = ill_q;
        valid_d  = 1'b0;
`ifdef EXEC_ALU_MULDIV_EN
        state_d  = state_q;
        cnt_d    = cnt_q;
        p_d      = p_q;
        m_d      = m_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        case (state_q)
            S_IDLE: if (io.start) begin
                if (is_md) begin
                    state_d  = S_RUN;
                    cnt_d    = 5'd0;
                    is_div_d = io.op[2];
                    neg_d    = sa ^ sb;
                    rneg_d   = sa;
                    m_d      = io.op[2] ? mb : ma;
                    p_d      = {32'd0, io.op[2] ? ma : mb};
                end else begin
                    result_d = sc_res;
                    ovf_d    = sc_ovf;
                    ill_d    = sc_ill;
                    valid_d  = 1'b1;
                end
            end
            S_RUN: begin
                p_d   = step_p;
                cnt_d = cnt_q + 5'd1;
                // Sign fix and HI/LO write happen on the final step so DONE already shows them.
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    ill_d   = 1'b0;
                    if (is_div_q) begin
                        hi_d  = rem_fix;
                        lo_d  = div0 ? 32'hFFFF_FFFF : quo_fix;
                        ovf_d = div0;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                        ovf_d        = 1'b0;
                    end
                    result_d = lo_d;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`else
        if (io.start) begin
            result_d = sc_res;
            ovf_d    = sc_ovf;
            ill_d    = sc_ill;
            valid_d  = 1'b1;
        end
`endif
        zf_d = valid_d ? (result_d == 32'd0) : zf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zf_q     <= 1'b0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            valid_q  <= 1'b0;
`ifdef EXEC_ALU_MULDIV_EN
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            p_q      <= '0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
`endif
        end else begin
            result_q <= result_d;
            zf_q     <= zf_d;
            ovf_q    <= ovf_d;
            ill_q    <= ill_d;
            valid_q  <= valid_d;
`ifdef EXEC_ALU_MULDIV_EN
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
            m_q      <= m_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
`endif
        end
    end

    assign io.result = result_q;
    assign io.zf     = zf_q;
    assign io.ovf    = ovf_q;
    assign io.ill    = ill_q;
    assign io.valid  = valid_q;
`ifdef EXEC_ALU_MULDIV_EN
    assign io.busy   = (state_q == S_RUN);
    assign io.hi     = hi_q;
    assign io.lo     = lo_q;
`else
    assign io.busy   = 1'b0;
    assign io.hi     = '0;
    assign io.lo     = '0;
`endif
endmodule

// File: tb/tb_exec_alu.sv
// Directed bench for exec_alu: single-cycle vector table, back-to-back issue, reset,
// and either the mul/div engine sequences or the illegal-op path depending on EXEC_ALU_MULDIV_EN.
module tb_exec_alu;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    exec_alu_if io ();
    exec_alu dut (.clk(clk), .rst_n(rst_n), .io(io));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        zf;
        logic        ovf;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        io.op    = op;
        io.a     = a;
        io.b     = b;
        io.shamt = sh;
        io.start = 1'b1;
        @(posedge clk);
        #1;
        io.start = 1'b0;
    endtask

`ifdef EXEC_ALU_MULDIV_EN
    task automatic run_md(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic eovf);
        logic ok;
        ok = 1'b1;
        issue(op, a, b, 5'd0);
        for (int i = 0; i < 32; i++) begin
            if (io.busy !== 1'b1 || io.valid !== 1'b0) ok = 1'b0;
            @(posedge clk);
            #1;
        end
        check({name, "_busy32"}, {63'd0, ok}, 64'd1);
        check({name, "_done"}, {59'd0, io.valid, io.busy, io.ovf, io.zf, io.ill},
              {59'd0, 1'b1, 1'b0, eovf, elo == 32'd0, 1'b0});
        check({name, "_hilo"}, {io.hi, io.lo}, {ehi, elo});
        check({name, "_res"}, {32'd0, io.result}, {32'd0, elo});
        @(posedge clk);
        #1;
        check({name, "_pulse"}, {63'd0, io.valid}, 64'd0);
    endtask
`endif

    initial begin
        logic seen;
        io.start = 1'b0;
        io.op    = 4'd0;
        io.a     = '0;
        io.b     = '0;
        io.shamt = '0;

        vecs[0]  = '{4'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  32'h00F0_1234, 1'b0, 1'b0};
        vecs[1]  = '{4'd1, 32'h0000_F000, 32'h0000_0F0F, 5'd0,  32'h0000_FF0F, 1'b0, 1'b0};
        vecs[2]  = '{4'd2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1};
        vecs[3]  = '{4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
        vecs[4]  = '{4'd3, 32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1};
        vecs[5]  = '{4'd3, 32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
        vecs[6]  = '{4'd4, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0};
        vecs[7]  = '{4'd4, 32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000, 1'b1, 1'b0};
        vecs[8]  = '{4'd5, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[9]  = '{4'd6, 32'hAAAA_5555, 32'hFFFF_0000, 5'd0,  32'h5555_5555, 1'b0, 1'b0};
        vecs[10] = '{4'd7, 32'h1234_5678, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0};
        vecs[11] = '{4'd8, 32'h0000_0000, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0};
        vecs[12] = '{4'd9, 32'h0000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0};
        vecs[13] = '{4'd9, 32'h0000_0000, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outs", {58'd0, io.busy, io.valid, io.zf, io.ovf, io.ill, 1'b0} |
              {32'd0, io.result}, 64'd0);
        check("reset_hilo", {io.hi, io.lo}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            check($sformatf("vec%0d_op%0d", i, vecs[i].op),
                  {28'd0, io.valid, io.result, io.zf, io.ovf, io.ill, io.busy},
                  {28'd0, 1'b1, vecs[i].res, vecs[i].zf, vecs[i].ovf, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        check("hold_after_valid", {30'd0, io.valid, io.result, io.zf},
              {30'd0, 1'b0, 32'h07FF_FFFF, 1'b0});

        // SUB then SLT with start held high across two edges
        io.op = 4'd3; io.a = 32'd5; io.b = 32'd5; io.start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b_sub", {30'd0, io.valid, io.result, io.zf}, {30'd0, 1'b1, 32'd0, 1'b1});
        io.op = 4'd4; io.a = 32'hFFFF_FFFF; io.b = 32'd1;
        @(posedge clk);
        #1;
        io.start = 1'b0;
        check("b2b_slt", {30'd0, io.valid, io.result, io.zf}, {30'd0, 1'b1, 32'd1, 1'b0});

`ifdef EXEC_ALU_MULDIV_EN
        run_md("mult", 4'd10, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        issue(4'd14, 32'd0, 32'd0, 5'd0);
        check("mfhi", {31'd0, io.valid, io.result}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        issue(4'd15, 32'd0, 32'd0, 5'd0);
        check("mflo", {31'd0, io.valid, io.result}, {31'd0, 1'b1, 32'hFFFF_FFEB});
        run_md("multu", 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_md("div_neg", 4'd12, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_md("divu_zero", 4'd13, 32'd9, 32'd0, 32'd9, 32'hFFFF_FFFF, 1'b1);
        run_md("div_min", 4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);

        // MULTU aborted by reset; an AND pulsed mid-run must be dropped
        issue(4'd11, 32'hFFFF_FFFF, 32'd3, 5'd0);
        io.op = 4'd0; io.a = 32'hFFFF_FFFF; io.b = 32'hFFFF_FFFF;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            io.start = (i == 5);
            if (io.valid !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        io.start = 1'b0;
        check("run_ignores_start", {62'd0, seen, io.busy}, {62'd0, 1'b0, 1'b1});
        rst_n = 1'b0;
        #1;
        check("abort_outs", {26'd0, io.busy, io.valid, io.zf, io.ovf, io.ill, io.result, 1'b0},
              64'd0);
        check("abort_hilo", {io.hi, io.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (io.valid !== 1'b0 || io.busy !== 1'b0) seen = 1'b1;
        end
        check("abort_no_valid", {63'd0, seen}, 64'd0);
`else
        issue(4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0);
        for (int op = 10; op < 16; op++) begin
            issue(4'(op), 32'h1234_5678, 32'd7, 5'd3);
            check($sformatf("ill_op%0d", op),
                  {27'd0, io.valid, io.result, io.zf, io.ovf, io.ill, io.busy},
                  {27'd0, 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0});
        end
        issue(4'd10, 32'hFFFF_FFFD, 32'd7, 5'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (io.busy !== 1'b0) seen = 1'b1;
            @(posedge clk);
            #1;
        end
        check("no_busy_no_hilo", {63'd0, seen} | {io.hi, io.lo}, 64'd0);
`endif

        issue(4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("pre_reset_add", {30'd0, io.result, io.ovf, io.ill}, {30'd0, 32'h8000_0000, 1'b1, 1'b0});
        rst_n = 1'b0;
        #1;
        check("final_reset", {26'd0, io.busy, io.valid, io.zf, io.ovf, io.ill, io.result, 1'b0},
              64'd0);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
